mem_stage_lsu: RTL and testbench

//  Parametrised MEM pipeline stage with a valid/ready data-SRAM interface. Supports multi-cycle memory latency and sub-word/64-bit load-store.

---
 rtl/mem_stage_lsu_pkg.sv | 35 +++
 rtl/mem_stage_lsu_if.sv | 21 ++
 rtl/mem_stage_lsu_align.sv | 34 +++
 rtl/mem_stage_lsu.sv | 118 +++++++++++
 tb/tb_mem_stage_lsu.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// lsu_pkg: shared LSU op encoding, FSM state codes and size/class helpers for the MEM stage.
package lsu_pkg;
    typedef enum logic [3:0] {
        OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD,
        OP_SB, OP_SH, OP_SW, OP_SD
    } lsu_op_e;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    function automatic int mem_to_wb_w(int xlen, int pc_w, int rfa_w);
        return 2 + pc_w + rfa_w + xlen;
    endfunction
    function automatic int mem_to_id_w(int xlen, int rfa_w);
        return 2 + rfa_w + xlen;
    endfunction
    function automatic logic is_load(lsu_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD};
    endfunction
    function automatic logic is_store(lsu_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction
    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(lsu_op_e op);
        return (op inside {OP_LB, OP_LBU, OP_SB}) ? 2'd0 :
               (op inside {OP_LH, OP_LHU, OP_SH}) ? 2'd1 :
               (op inside {OP_LW, OP_LWU, OP_SW}) ? 2'd2 : 2'd3;
    endfunction
    function automatic lsu_op_e legal_op(lsu_op_e op, int xlen);
        return (xlen == 32 && op inside {OP_LD, OP_LWU, OP_SD}) ? OP_NONE : op;
    endfunction
    function automatic logic misaligned(lsu_op_e op, logic [2:0] off);
        return (is_load(op) | is_store(op)) && |(off & 3'((4'd1 << op_size(op)) - 4'd1));
    endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: valid/ready data-SRAM request and response bus.
interface mem_stage_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [XLEN/8-1:0]   req_wstrb;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_rdata;
    modport master (
        output req_valid, req_wstrb, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_wstrb, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: store strobe/lane replication, load lane extract with sign/zero extend, misalign detect.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_op_e           op_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   ldata_o,
    output logic              misalign_o
);
    logic [1:0]        sz;
    logic              sgn;
    logic [XLEN/8-1:0] mask;
    logic [XLEN-1:0]   sh;
    always_comb begin
        sz         = op_size(op_i);
        sgn        = op_i inside {OP_LB, OP_LH, OP_LW};
        mask       = (XLEN/8)'((9'd1 << (4'd1 << sz)) - 9'd1);
        wstrb_o    = is_store(op_i) ? mask << off_i : '0;
        wdata_o    = sz == 2'd0 ? {(XLEN/8){sdata_i[7:0]}} :
                     sz == 2'd1 ? {(XLEN/16){sdata_i[15:0]}} :
                     sz == 2'd2 ? {(XLEN/32){sdata_i[31:0]}} : sdata_i;
        sh         = rdata_i >> {off_i, 3'b000};
        ldata_o    = sz == 2'd0 ? (sgn ? XLEN'($signed(sh[7:0]))  : XLEN'(sh[7:0]))  :
                     sz == 2'd1 ? (sgn ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0])) :
                     sz == 2'd2 ? (sgn ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0])) : sh;
        misalign_o = misaligned(op_i, off_i);
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with multi-cycle SRAM handshake, sub-word load/store,
// misalign exceptions and a MEM->ID forwarding bus with load-pending flag.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int PC_W    = 32,
    parameter int RFA_W   = 5,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    output logic               stallreq_o,
    input  logic               ex_valid_i,
    input  logic [PC_W-1:0]    ex_pc_i,
    input  logic [3:0]         ex_op_i,
    input  logic [ADDR_W-1:0]  ex_addr_i,
    input  logic [XLEN-1:0]    ex_sdata_i,
    input  logic               ex_rf_we_i,
    input  logic [RFA_W-1:0]   ex_rf_waddr_i,
    input  logic [XLEN-1:0]    ex_result_i,
    mem_stage_lsu_if.master    mem,
    output logic               wb_valid_o,
    output logic [PC_W-1:0]    wb_pc_o,
    output logic               wb_rf_we_o,
    output logic [RFA_W-1:0]   wb_rf_waddr_o,
    output logic [XLEN-1:0]    wb_rf_wdata_o,
    output logic               fwd_we_o,
    output logic [RFA_W-1:0]   fwd_waddr_o,
    output logic [XLEN-1:0]    fwd_wdata_o,
    output logic               fwd_load_pending_o,
    output logic               excp_misalign_o,
    output logic [ADDR_W-1:0]  excp_badaddr_o
);
    localparam int OW = $clog2(XLEN/8);
    logic              valid_q, valid_d, rf_we_q, rf_we_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    lsu_op_e           op_q, op_d, op_in;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d, result_q, result_d, ldata_q, ldata_d, ld_fmt, wdata;
    logic [RFA_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [1:0]        state_q, state_d, adv;
    logic              cap, bub, go_req, mis, done, stall_unused;
    assign stall_unused = ^{stall_i[2:0], stall_i[STALL_W-1:5]};
    lsu_align #(.XLEN(XLEN)) u_align (
        .op_i       (op_q),
        .off_i      (3'(addr_q[OW-1:0])),
        .sdata_i    (sdata_q),
        .rdata_i    (mem.rsp_rdata),
        .wstrb_o    (mem.req_wstrb),
        .wdata_o    (mem.req_wdata),
        .ldata_o    (ld_fmt),
        .misalign_o (mis)
    );
    always_comb begin
        cap        = !stall_i[3];
        bub        = stall_i[3] & !stall_i[4];
        op_in      = legal_op(lsu_op_e'(ex_op_i), XLEN);
        go_req     = ex_valid_i & (is_load(op_in) | is_store(op_in)) & !misaligned(op_in, 3'(ex_addr_i[OW-1:0]));
        valid_d    = bub ? 1'b0 : cap ? ex_valid_i : valid_q;
        pc_d       = cap ? ex_pc_i : pc_q;
        op_d       = cap ? op_in : op_q;
        addr_d     = cap ? ex_addr_i : addr_q;
        sdata_d    = cap ? ex_sdata_i : sdata_q;
        rf_we_d    = cap ? ex_rf_we_i : rf_we_q;
        rf_waddr_d = cap ? ex_rf_waddr_i : rf_waddr_q;
        result_d   = cap ? ex_result_i : result_q;
        adv        = state_q == S_REQ  ? (mem.req_ready ? (is_store(op_q) ? S_DONE : S_WAIT) : S_REQ) :
                     state_q == S_WAIT ? (mem.rsp_valid ? S_DONE : S_WAIT) : state_q;
        state_d    = bub ? S_IDLE : cap ? (go_req ? S_REQ : S_DONE) : adv;
        ldata_d    = (state_q == S_WAIT && mem.rsp_valid) ? ld_fmt : ldata_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            sdata_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
            state_q    <= S_IDLE;
            ldata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            result_q   <= result_d;
            state_q    <= state_d;
            ldata_q    <= ldata_d;
        end
    end
    always_comb begin
        done               = state_q == S_DONE;
        mem.req_valid      = state_q == S_REQ;
        mem.req_addr       = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
        stallreq_o         = state_q == S_REQ || state_q == S_WAIT;
        wb_valid_o         = done & valid_q;
        wb_pc_o            = pc_q;
        wb_rf_we_o         = wb_valid_o & rf_we_q & !is_store(op_q) & !mis;
        wb_rf_waddr_o      = rf_waddr_q;
        wdata              = is_load(op_q) ? ldata_q : result_q;
        wb_rf_wdata_o      = wdata;
        fwd_we_o           = wb_rf_we_o;
        fwd_waddr_o        = valid_q ? rf_waddr_q : '0;
        fwd_wdata_o        = wb_valid_o ? wdata : '0;
        fwd_load_pending_o = valid_q & is_load(op_q) & !done;
        excp_misalign_o    = wb_valid_o & mis;
        excp_badaddr_o     = excp_misalign_o ? addr_q : '0;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vectors against 32- and 64-bit instances of the MEM stage.
module tb_mem_stage_lsu;
    import lsu_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic [5:0]  stall;
    logic        ex_valid, ex_rf_we, sel;
    logic [31:0] ex_pc, ex_addr;
    logic [3:0]  ex_op;
    logic [63:0] ex_sdata, ex_result;
    logic [4:0]  ex_rf_waddr;
    int          errs = 0, checks = 0, n;
    logic        stallreq_a, wb_valid_a, wb_rf_we_a, fwd_we_a, pend_a, excp_a;
    logic        stallreq_b, wb_valid_b, wb_rf_we_b, fwd_we_b, pend_b, excp_b;
    logic [31:0] wb_pc_a, wb_pc_b, bad_a, bad_b, wdata_a, fwd_wdata_a;
    logic [63:0] wdata_b, fwd_wdata_b;
    logic [4:0]  waddr_a, waddr_b, fwd_waddr_a, fwd_waddr_b;
    mem_stage_lsu_if #(.XLEN(32)) ma ();
    mem_stage_lsu_if #(.XLEN(64)) mb ();
    mem_stage_lsu #(.XLEN(32)) ua (
        .clk(clk), .rst(rst), .stall_i(stall), .stallreq_o(stallreq_a),
        .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_op_i(ex_op), .ex_addr_i(ex_addr),
        .ex_sdata_i(ex_sdata[31:0]), .ex_rf_we_i(ex_rf_we), .ex_rf_waddr_i(ex_rf_waddr),
        .ex_result_i(ex_result[31:0]), .mem(ma),
        .wb_valid_o(wb_valid_a), .wb_pc_o(wb_pc_a), .wb_rf_we_o(wb_rf_we_a),
        .wb_rf_waddr_o(waddr_a), .wb_rf_wdata_o(wdata_a), .fwd_we_o(fwd_we_a),
        .fwd_waddr_o(fwd_waddr_a), .fwd_wdata_o(fwd_wdata_a), .fwd_load_pending_o(pend_a),
        .excp_misalign_o(excp_a), .excp_badaddr_o(bad_a)
    );
    mem_stage_lsu #(.XLEN(64)) ub (
        .clk(clk), .rst(rst), .stall_i(stall), .stallreq_o(stallreq_b),
        .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_op_i(ex_op), .ex_addr_i(ex_addr),
        .ex_sdata_i(ex_sdata), .ex_rf_we_i(ex_rf_we), .ex_rf_waddr_i(ex_rf_waddr),
        .ex_result_i(ex_result), .mem(mb),
        .wb_valid_o(wb_valid_b), .wb_pc_o(wb_pc_b), .wb_rf_we_o(wb_rf_we_b),
        .wb_rf_waddr_o(waddr_b), .wb_rf_wdata_o(wdata_b), .fwd_we_o(fwd_we_b),
        .fwd_waddr_o(fwd_waddr_b), .fwd_wdata_o(fwd_wdata_b), .fwd_load_pending_o(pend_b),
        .excp_misalign_o(excp_b), .excp_badaddr_o(bad_b)
    );
    logic [63:0] o_rv, o_raddr, o_wstrb, o_rwdata, o_sreq, o_wbv, o_we, o_wdata, o_fwe, o_fwdata, o_pend, o_excp, o_bad;
    assign o_rv     = 64'(sel ? mb.req_valid : ma.req_valid);
    assign o_raddr  = 64'(sel ? mb.req_addr : ma.req_addr);
    assign o_wstrb  = sel ? 64'(mb.req_wstrb) : 64'(ma.req_wstrb);
    assign o_rwdata = sel ? mb.req_wdata : 64'(ma.req_wdata);
    assign o_sreq   = 64'(sel ? stallreq_b : stallreq_a);
    assign o_wbv    = 64'(sel ? wb_valid_b : wb_valid_a);
    assign o_we     = 64'(sel ? wb_rf_we_b : wb_rf_we_a);
    assign o_wdata  = sel ? wdata_b : 64'(wdata_a);
    assign o_fwe    = 64'(sel ? fwd_we_b : fwd_we_a);
    assign o_fwdata = sel ? fwd_wdata_b : 64'(fwd_wdata_a);
    assign o_pend   = 64'(sel ? pend_b : pend_a);
    assign o_excp   = 64'(sel ? excp_b : excp_a);
    assign o_bad    = 64'(sel ? bad_b : bad_a);
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic mem_drive(input logic ready, input logic rv, input logic [63:0] rdata);
        ma.req_ready = ready;
        mb.req_ready = ready;
        ma.rsp_valid = rv;
        mb.rsp_valid = rv;
        ma.rsp_rdata = rdata[31:0];
        mb.rsp_rdata = rdata;
    endtask
    task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [63:0] sdata, input logic [63:0] result);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_addr   = addr;
        ex_sdata  = sdata;
        ex_result = result;
        ex_pc     = addr + 32'h1000;
        stall     = 6'b000000;
        step();
        ex_valid  = 1'b0;
        stall     = 6'b011000;
    endtask
    task automatic load(input string tag, input lsu_op_e op, input logic [31:0] addr, input logic [63:0] rdata, input logic [63:0] exp);
        issue(op, addr, 64'd0, 64'd0);
        check({tag, "_req"}, o_rv, 64'd1);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        mem_drive(1'b0, 1'b1, rdata);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        check({tag, "_wbv"}, o_wbv, 64'd1);
        check({tag, "_data"}, o_wdata, exp);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; sel = 1'b0; stall = 6'b000000;
        ex_valid = 1'b0; ex_op = 4'd0; ex_addr = '0; ex_sdata = '0; ex_result = '0;
        ex_pc = '0; ex_rf_we = 1'b1; ex_rf_waddr = 5'd7;
        mem_drive(1'b0, 1'b0, 64'd0);
        step(); step();
        check("rst_req", o_rv, 64'd0);
        check("rst_wbv", o_wbv, 64'd0);
        check("rst_sreq", o_sreq, 64'd0);
        check("rst_excp", o_excp, 64'd0);
        check("rst_pend", o_pend, 64'd0);
        rst = 1'b0;
        step();
        issue(OP_LW, 32'h100, 64'd0, 64'd0);
        check("lw_addr", o_raddr, 64'h100);
        check("lw_wstrb", o_wstrb, 64'h0);
        check("lw_pend_req", o_pend, 64'd1);
        n = int'(o_sreq[0]);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        n += int'(o_sreq[0]);
        check("lw_pend_wait", o_pend, 64'd1);
        mem_drive(1'b0, 1'b0, 64'd0);
        step();
        n += int'(o_sreq[0]);
        mem_drive(1'b0, 1'b1, 64'hDEADBEEF);
        step();
        n += int'(o_sreq[0]);
        mem_drive(1'b0, 1'b0, 64'd0);
        check("lw_stall_cycles", 64'(n), 64'd3);
        check("lw_wbv", o_wbv, 64'd1);
        check("lw_data", o_wdata, 64'hDEADBEEF);
        check("lw_we", o_we, 64'd1);
        check("lw_fwd", o_fwdata, 64'hDEADBEEF);
        check("lw_pend_done", o_pend, 64'd0);
        step();
        check("lw_hold", o_wdata, 64'hDEADBEEF);
        load("lb", OP_LB, 32'h103, 64'h80FFFF7F, 64'hFFFFFF80);
        load("lbu", OP_LBU, 32'h103, 64'h80FFFF7F, 64'h00000080);
        load("lhu", OP_LHU, 32'h102, 64'h80FFFF7F, 64'h000080FF);
        load("lh", OP_LH, 32'h102, 64'h80FFFF7F, 64'hFFFF80FF);
        issue(OP_SH, 32'h106, 64'h1234ABCD, 64'd0);
        check("sh_req", o_rv, 64'd1);
        check("sh_addr", o_raddr, 64'h104);
        check("sh_wstrb", o_wstrb, 64'hC);
        check("sh_wdata", o_rwdata, 64'hABCDABCD);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        check("sh_wbv", o_wbv, 64'd1);
        check("sh_we", o_we, 64'd0);
        check("sh_sreq", o_sreq, 64'd0);
        issue(OP_SB, 32'h101, 64'h000000A5, 64'd0);
        check("sb_wstrb", o_wstrb, 64'h2);
        check("sb_wdata", o_rwdata, 64'hA5A5A5A5);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        issue(OP_LW, 32'h101, 64'd0, 64'd0);
        check("mis_req", o_rv, 64'd0);
        check("mis_excp", o_excp, 64'd1);
        check("mis_bad", o_bad, 64'h101);
        check("mis_we", o_we, 64'd0);
        check("mis_sreq", o_sreq, 64'd0);
        issue(OP_LW, 32'h200, 64'd0, 64'd0);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        check("rstmid_sreq_before", o_sreq, 64'd1);
        rst = 1'b1;
        #2;
        check("rstmid_sreq_async", o_sreq, 64'd0);
        check("rstmid_pend_async", o_pend, 64'd0);
        step();
        rst = 1'b0;
        mem_drive(1'b0, 1'b1, 64'h12345678);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        check("stray_wbv", o_wbv, 64'd0);
        check("stray_req", o_rv, 64'd0);
        check("stray_data", o_wdata, 64'd0);
        issue(OP_NONE, 32'h0, 64'd0, 64'h55);
        check("alu_wbv", o_wbv, 64'd1);
        check("alu_data", o_wdata, 64'h55);
        check("alu_fwe", o_fwe, 64'd1);
        stall = 6'b001000;
        step();
        check("bub_wbv", o_wbv, 64'd0);
        check("bub_we", o_we, 64'd0);
        sel = 1'b1;
        load("ld64", OP_LD, 32'h08, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
        load("lw64", OP_LW, 32'h0C, 64'h8000000100000000, 64'hFFFFFFFF80000001);
        load("lwu64", OP_LWU, 32'h0C, 64'h8000000100000000, 64'h0000000080000001);
        issue(OP_SW, 32'h14, 64'h00000000CAFEF00D, 64'd0);
        check("sw64_wstrb", o_wstrb, 64'hF0);
        check("sw64_wdata", o_rwdata, 64'hCAFEF00DCAFEF00D);
        mem_drive(1'b1, 1'b0, 64'd0);
        step();
        mem_drive(1'b0, 1'b0, 64'd0);
        sel = 1'b0;
        issue(OP_LD, 32'h08, 64'd0, 64'hCAFE);
        check("ld32_req", o_rv, 64'd0);
        check("ld32_wbv", o_wbv, 64'd1);
        check("ld32_data", o_wdata, 64'hCAFE);
        check("ld32_excp", o_excp, 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
